// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline-control types for the 5-stage RV32I core
package riscv_pipe_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_write;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FLOW   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam pipe_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Hold PC and IF/ID, bubble into EX, let the load drain toward MEM.
    localparam pipe_ctrl_t CTRL_LDUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    function automatic logic reg_match(input logic use_src, input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src && (dst == src);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall, branch flush and memory-wait freeze control
module hazard_stall_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_mem_read,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    hz_state_e      state, state_next;
    logic [WCW-1:0] wait_cnt, wait_next;
    logic           load_use;
    logic           stall_inc, flush_inc, timeout_set;
    pipe_ctrl_t     ctrl;

    assign load_use = EX_mem_read && (EX_rd != REG_X0) &&
                      (reg_match(ID_use_rs1, ID_rs1, EX_rd) ||
                       reg_match(ID_use_rs2, ID_rs2, EX_rd));

    always_comb begin
        ctrl        = CTRL_FLOW;
        state_next  = state;
        wait_next   = wait_cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        timeout_set = 1'b0;

        if (mem_busy) begin
            ctrl       = CTRL_FREEZE;
            stall_inc  = 1'b1;
            state_next = FREEZE;
            if (state == RUN) begin
                wait_next = WCW'(1);
            end else begin
                if (wait_cnt < WAIT_MAX) begin
                    wait_next = wait_cnt + 1'b1;
                end
                // Fires on the cycle whose update brings wait_cnt to MAX_WAIT.
                if (wait_cnt >= WAIT_LAST) begin
                    timeout_set = 1'b1;
                end
            end
        end else begin
            // Leaving a freeze resolves any branch held through it exactly once.
            state_next = RUN;
            wait_next  = '0;
            if (branch_taken) begin
                ctrl      = CTRL_BRANCH;
                flush_inc = 1'b1;
            end else if (load_use) begin
                ctrl      = CTRL_LDUSE;
                stall_inc = 1'b1;
            end
        end

        if (reset) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (reset),
        .en  (stall_inc),
        .q   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (reset),
        .en  (flush_inc),
        .q   (flush_events)
    );

    assign pc_write     = ctrl.pc_write;
    assign IF_ID_write  = ctrl.if_id_write;
    assign IF_ID_flush  = ctrl.if_id_flush;
    assign ID_EX_flush  = ctrl.id_ex_flush;
    assign EX_MEM_write = ctrl.ex_mem_write;
    assign MEM_WB_write = ctrl.mem_wb_write;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam logic [5:0] C_FLOW = 6'b110011;
    localparam logic [5:0] C_BR   = 6'b111111;
    localparam logic [5:0] C_LU   = 6'b000111;
    localparam logic [5:0] C_FRZ  = 6'b000000;
    localparam logic [5:0] C_RST  = 6'b001100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, mem_busy = 1'b0, branch_taken = 1'b0, EX_mem_read = 1'b0;
    logic [4:0] EX_rd = '0, ID_rs1 = '0, ID_rs2 = '0;
    logic       ID_use_rs1 = 1'b0, ID_use_rs2 = 1'b0;

    logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_write;
    logic [31:0] stall_cycles, flush_events;
    logic        mem_timeout;

    logic        pc_write4, IF_ID_write4, IF_ID_flush4, ID_EX_flush4, EX_MEM_write4, MEM_WB_write4;
    logic [3:0]  stall4, flush4;
    logic        mem_timeout4;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
        .EX_mem_read(EX_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_timeout(mem_timeout)
    );

    hazard_stall_ctrl #(.MAX_WAIT(16), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
        .EX_mem_read(EX_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write4), .IF_ID_write(IF_ID_write4), .IF_ID_flush(IF_ID_flush4),
        .ID_EX_flush(ID_EX_flush4), .EX_MEM_write(EX_MEM_write4), .MEM_WB_write(MEM_WB_write4),
        .stall_cycles(stall4), .flush_events(flush4), .mem_timeout(mem_timeout4)
    );

    typedef struct {
        string       tag;
        logic [5:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic       nx_reset, nx_busy, nx_br, nx_mr, nx_u1, nx_u2;
    logic [4:0] nx_rd, nx_rs1, nx_rs2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic rst, input logic busy, input logic br, input logic mr,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
        nx_reset = rst; nx_busy = busy; nx_br = br; nx_mr = mr;
        nx_rd = rd; nx_rs1 = rs1; nx_rs2 = rs2; nx_u1 = u1; nx_u2 = u2;
    endtask

    // One clock: apply the staged inputs, queue the expectation, compare mid-cycle.
    task automatic cyc(input string tag, input logic [5:0] ec, input logic [31:0] es,
                       input logic [31:0] ef, input logic et);
        exp_t e;
        @(posedge clk);
        #1;
        reset = nx_reset; mem_busy = nx_busy; branch_taken = nx_br; EX_mem_read = nx_mr;
        EX_rd = nx_rd; ID_rs1 = nx_rs1; ID_rs2 = nx_rs2; ID_use_rs1 = nx_u1; ID_use_rs2 = nx_u2;
        sb.push_back('{tag, ec, es, ef, et});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, "/ctrl"}, {26'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
                               EX_MEM_write, MEM_WB_write}, {26'd0, e.ctrl});
        chk({e.tag, "/stall"}, stall_cycles, e.stall);
        chk({e.tag, "/flush"}, flush_events, e.flush);
        chk({e.tag, "/tmo"}, {31'd0, mem_timeout}, {31'd0, e.tmo});
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc("rst0", C_RST, 0, 0, 1'b0);
        cyc("rst1", C_RST, 0, 0, 1'b0);
        idle_in();
        cyc("post_rst", C_FLOW, 0, 0, 1'b0);

        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        cyc("lu_rs1", C_LU, 0, 0, 1'b0);
        idle_in();
        cyc("lu_after", C_FLOW, 1, 0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc("lu_x0", C_FLOW, 1, 0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
        cyc("lu_rs2", C_LU, 1, 0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
        cyc("lu_unused", C_FLOW, 2, 0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
        cyc("lu_noload", C_FLOW, 2, 0, 1'b0);

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc("rst_a", C_RST, 2, 0, 1'b0);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        cyc("br_lu", C_BR, 0, 0, 1'b0);
        idle_in();
        cyc("br_lu_after", C_FLOW, 0, 1, 1'b0);

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc("rst_b", C_RST, 0, 1, 1'b0);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc("frz1", C_FRZ, 0, 0, 1'b0);
        cyc("frz2", C_FRZ, 1, 0, 1'b0);
        cyc("frz3", C_FRZ, 2, 0, 1'b0);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc("frz_exit_br", C_BR, 3, 0, 1'b0);
        idle_in();
        cyc("frz_done", C_FLOW, 3, 1, 1'b0);

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc("rst_c", C_RST, 3, 1, 1'b0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cyc($sformatf("tmo_frz%0d", k), C_FRZ, 32'(k - 1), 0, (k >= 17));
        end
        idle_in();
        cyc("tmo_exit", C_FLOW, 20, 0, 1'b1);
        cyc("tmo_sticky", C_FLOW, 20, 0, 1'b1);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc("tmo_rst", C_RST, 20, 0, 1'b1);
        idle_in();
        cyc("tmo_cleared", C_FLOW, 0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
            cyc($sformatf("sat_lu%0d", i), C_LU, 32'(i), 0, 1'b0);
            idle_in();
            cyc($sformatf("sat_gap%0d", i), C_FLOW, 32'(i + 1), 0, 1'b0);
            if (i == 13) begin
                chk("sat4_at14", {28'd0, stall4}, 32'h0000000E);
            end
        end
        chk("sat4_final", {28'd0, stall4}, 32'h0000000F);
        chk("sat4_flush", {28'd0, flush4}, 32'h00000000);
        chk("sat32_final", stall_cycles, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
